// File: rtl/rom_rgb_arbiter_pkg.sv
// Shared constants, state encoding and small helpers for the sprite-ROM arbiter.
package rom_rgb_arbiter_pkg;

  localparam int ROM_ADDR_W      = 9;
  localparam int ROM_DATA_W      = 24;
  localparam int ROM_DEPTH_WORDS = 288;
  localparam int ROM_RD_LATENCY  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Distance of requester k from the round-robin pointer, searching upward with wrap.
  function automatic int rr_distance(input int k, input int ptr, input int n);
    int d;
    d = k - ptr;
    if (d < 0) d = d + n;
    return d;
  endfunction

endpackage

// File: rtl/rom_rgb_arbiter_rr_arbiter.sv
// Combinational round-robin winner search: first asserted request at or after ptr.
module rr_arbiter
  import rom_rgb_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  int best_d;

  always_comb begin
    grant   = '0;
    idx     = '0;
    best_d  = N_REQ;
    for (int k = 0; k < N_REQ; k++) begin
      if (req[k] && (rr_distance(k, int'(ptr), N_REQ) < best_d)) begin
        best_d   = rr_distance(k, int'(ptr), N_REQ);
        grant    = '0;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/rom_rgb_arbiter.sv
// Round-robin sharing of the rom_rgb sprite ROM between N_REQ pixel requesters.
// Optional WAIT-state timeout is enabled by defining ROM_RGB_ARB_TIMEOUT_EN.
module rom_rgb_arbiter
  import rom_rgb_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ROM_DEPTH = ROM_DEPTH_WORDS
`ifdef ROM_RGB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 8
`endif
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [ROM_ADDR_W*N_REQ-1:0] i_address,
  output logic [N_REQ-1:0]            o_ack,
  output logic [ROM_DATA_W-1:0]       o_rgb_data,
  output logic                        o_err,
  output logic                        o_busy,
  output logic                        o_rom_read,
  output logic [ROM_ADDR_W-1:0]       o_rom_address,
  input  logic [ROM_DATA_W-1:0]       i_rom_rgb_data,
  input  logic                        i_rom_valid
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam logic [ROM_ADDR_W:0] DEPTH_LIM = (ROM_ADDR_W + 1)'(ROM_DEPTH);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ROM_ADDR_W-1:0]   addr_q, addr_d;
  logic [N_REQ-1:0]        grant;
  logic [IDX_W-1:0]        win_idx;
  logic                    any_req;
  logic [ROM_ADDR_W-1:0]   sel_addr;
  logic [N_REQ-1:0]        ack_d;
  logic [ROM_DATA_W-1:0]   rgb_d;
  logic                    err_d;
  logic                    read_d;
  logic                    busy_d;

`ifdef ROM_RGB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;

  // Counter runs only in WAIT, so it reads zero on every WAIT entry.
  always_comb begin
    cnt_d   = '0;
    expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    if (state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
  end
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (i_req),
    .ptr     (ptr_q),
    .grant   (grant),
    .idx     (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) sel_addr = i_address[k*ROM_ADDR_W +: ROM_ADDR_W];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    ack_d   = '0;
    rgb_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          idx_d  = win_idx;
          addr_d = sel_addr;
          if ({1'b0, sel_addr} < DEPTH_LIM) begin
            state_d = ST_ISSUE;
          end else begin
            // Rejected without touching the ROM; still consumes its round-robin turn.
            state_d = ST_ACK;
            ack_d   = grant;
            err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_rom_valid) begin
          state_d       = ST_ACK;
          ack_d[idx_q]  = 1'b1;
          rgb_d         = i_rom_rgb_data;
        end
`ifdef ROM_RGB_ARB_TIMEOUT_EN
        else if (expired) begin
          state_d       = ST_ACK;
          ack_d[idx_q]  = 1'b1;
          err_d         = 1'b1;
        end
`endif
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    read_d = (state_d == ST_ISSUE);
    busy_d = (state_d != ST_IDLE);
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      addr_q        <= '0;
      o_ack         <= '0;
      o_rgb_data    <= '0;
      o_err         <= 1'b0;
      o_busy        <= 1'b0;
      o_rom_read    <= 1'b0;
      o_rom_address <= '0;
`ifdef ROM_RGB_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      o_ack         <= ack_d;
      o_rgb_data    <= rgb_d;
      o_err         <= err_d;
      o_busy        <= busy_d;
      o_rom_read    <= read_d;
      o_rom_address <= addr_d;
`ifdef ROM_RGB_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom_rgb_arbiter.sv
// Directed bench for rom_rgb_arbiter with a behavioural two-cycle rom_rgb model.
module tb_rom_rgb_arbiter;
  import rom_rgb_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_r;
  logic [26:0] addr_bus;
  logic [2:0]  ack;
  logic [23:0] rgb;
  logic        err;
  logic        busy;
  logic        rom_read;
  logic [8:0]  rom_addr;
  logic [23:0] rom_data;
  logic        rom_valid;
  logic        rom_stall;
  logic        force_valid;

  int n_tests = 0;
  int n_fail  = 0;

  rom_rgb_arbiter dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req_r),
    .i_address      (addr_bus),
    .o_ack          (ack),
    .o_rgb_data     (rgb),
    .o_err          (err),
    .o_busy         (busy),
    .o_rom_read     (rom_read),
    .o_rom_address  (rom_addr),
    .i_rom_rgb_data (rom_data),
    .i_rom_valid    (rom_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] rom_word(input logic [8:0] a);
    if (a == 9'd5) return 24'hFF0000;
    return {8'h3C, 7'b0, a};
  endfunction

  logic [ROM_RD_LATENCY-1:0] vpipe = '0;
  logic [8:0] apipe [ROM_RD_LATENCY] = '{default: '0};

  always @(posedge clk) begin
    vpipe    <= {vpipe[ROM_RD_LATENCY-2:0], rom_read};
    apipe[0] <= rom_addr;
    for (int i = 1; i < ROM_RD_LATENCY; i++) apipe[i] <= apipe[i-1];
  end

  assign rom_valid = (vpipe[ROM_RD_LATENCY-1] & ~rom_stall) | force_valid;
  assign rom_data  = rom_word(apipe[ROM_RD_LATENCY-1]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [8:0]  a0, a1, a2;
    logic [2:0]  ack;
    logic [23:0] data;
    logic        err;
    int          lat;
    int          reads;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] r, input logic [8:0] a0, input logic [8:0] a1,
                              input logic [8:0] a2, input logic [2:0] k, input logic [23:0] d,
                              input logic e, input int l, input int rd);
    vec_t v;
    v.req = r; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.ack = k; v.data = d; v.err = e; v.lat = l; v.reads = rd;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int cyc;
    int reads;
    bit got;
    cyc = 0; reads = 0; got = 0;
    req_r    = v.req;
    addr_bus = {v.a2, v.a1, v.a0};
    while (cyc < 12 && !got) begin
      @(negedge clk);
      cyc++;
      if (rom_read) reads++;
      if (ack != 3'b000) got = 1;
    end
    check($sformatf("v%0d_latency", id), cyc, v.lat);
    check($sformatf("v%0d_ack", id), ack, v.ack);
    check($sformatf("v%0d_data", id), rgb, v.data);
    check($sformatf("v%0d_err", id), err, v.err);
    check($sformatf("v%0d_busy_at_ack", id), busy, 1);
    check($sformatf("v%0d_reads", id), reads, v.reads);
    req_r = 3'b000;
    @(negedge clk);
    check($sformatf("v%0d_ack_one_cycle", id), ack, 0);
    check($sformatf("v%0d_idle_busy", id), busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int cyc, nacks, last_ack, last_read, min_gap, acks_seen;
    logic [2:0] exp_seq [4];
    logic [23:0] exp_dat [4];
    bit pend;

    vecs[0] = mk(3'b001, 9'd5,  9'd0,   9'd0,   3'b001, 24'hFF0000, 1'b0, 4, 1);
    vecs[1] = mk(3'b001, 9'd10, 9'd0,   9'd0,   3'b001, 24'h3C000A, 1'b0, 4, 1);
    vecs[2] = mk(3'b111, 9'd7,  9'd8,   9'd9,   3'b010, 24'h3C0008, 1'b0, 4, 1);
    vecs[3] = mk(3'b011, 9'd3,  9'd300, 9'd0,   3'b001, 24'h3C0003, 1'b0, 4, 1);
    vecs[4] = mk(3'b010, 9'd0,  9'd300, 9'd0,   3'b010, 24'h000000, 1'b1, 1, 0);
    vecs[5] = mk(3'b101, 9'd1,  9'd0,   9'd287, 3'b100, 24'h3C011F, 1'b0, 4, 1);
    vecs[6] = mk(3'b100, 9'd0,  9'd0,   9'd288, 3'b100, 24'h000000, 1'b1, 1, 0);
    vecs[7] = mk(3'b110, 9'd0,  9'd511, 9'd0,   3'b010, 24'h000000, 1'b1, 1, 0);
    vecs[8] = mk(3'b111, 9'd4,  9'd6,   9'd9,   3'b100, 24'h3C0009, 1'b0, 4, 1);
    vecs[9] = mk(3'b111, 9'd4,  9'd6,   9'd9,   3'b001, 24'h3C0004, 1'b0, 4, 1);

    rst_n = 1'b0; req_r = '0; addr_bus = '0; rom_stall = 1'b0; force_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_data", rgb, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_read", rom_read, 0);
    check("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while waiting on the ROM: outputs clear at once, stale valid is dropped.
    req_r = 3'b001; addr_bus = {9'd0, 9'd0, 9'd20};
    repeat (2) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    check("rst_mid_addr_before", rom_addr, 20);
    rst_n = 1'b0; req_r = 3'b000;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", rom_addr, 0);
    check("rst_mid_ack", ack, 0);
    #2 rst_n = 1'b1;
    acks_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack != 3'b000 || busy) acks_seen++;
    end
    check("rst_mid_no_ack", acks_seen, 0);

    // Continuous contention from pointer 0.
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_dat = '{24'h3C0000, 24'h3C0001, 24'h3C0002, 24'h3C0000};
    req_r = 3'b111; addr_bus = {9'd2, 9'd1, 9'd0};
    cyc = 0; nacks = 0; last_ack = 0; last_read = -1; min_gap = 99;
    while (cyc < 30 && nacks < 4) begin
      @(negedge clk);
      cyc++;
      if (rom_read) begin
        if (last_read >= 0 && (cyc - last_read - 1) < min_gap) min_gap = cyc - last_read - 1;
        last_read = cyc;
      end
      if (ack != 3'b000) begin
        check($sformatf("cont_ack%0d", nacks), ack, exp_seq[nacks]);
        check($sformatf("cont_data%0d", nacks), rgb, exp_dat[nacks]);
        if (nacks == 0) check("cont_first_latency", cyc, 4);
        else check($sformatf("cont_spacing%0d", nacks), cyc - last_ack, 5);
        last_ack = cyc;
        nacks++;
        if (nacks == 4) req_r = 3'b000;
      end
    end
    check("cont_ack_count", nacks, 4);
    check("cont_read_gap", min_gap, 4);
    @(negedge clk);

    // ROM stalled: timeout build gives an error ack, default build waits forever.
    rom_stall = 1'b1;
    req_r = 3'b001; addr_bus = {9'd0, 9'd0, 9'd5};
`ifdef ROM_RGB_ARB_TIMEOUT_EN
    cyc = 0;
    while (cyc < 20 && ack == 3'b000) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_latency", cyc, 10);
    check("tmo_ack", ack, 3'b001);
    check("tmo_err", err, 1);
    check("tmo_data", rgb, 0);
    req_r = 3'b000;
    @(negedge clk);
    req_r = 3'b001;
    cyc = 0;
    while (cyc < 20 && ack == 3'b000) begin
      @(negedge clk);
      cyc++;
      force_valid = (cyc == 9);
    end
    force_valid = 1'b0;
    check("tmo_race_latency", cyc, 10);
    check("tmo_race_err", err, 0);
    check("tmo_race_data", rgb, 24'hFF0000);
    req_r = 3'b000;
    @(negedge clk);
`else
    acks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != 3'b000) acks_seen++;
    end
    check("stall_no_ack", acks_seen, 0);
    check("stall_busy", busy, 1);
`endif
    rom_stall = 1'b0;
    req_r = 3'b000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: requester 0 re-requests right after each ack while requester 2 holds.
    req_r = 3'b101; addr_bus = {9'd12, 9'd0, 9'd11};
    cyc = 0; nacks = 0; pend = 0; last_ack = 0;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b100;
    exp_dat[0] = 24'h3C000B; exp_dat[1] = 24'h3C000C;
    while (cyc < 20 && last_ack == 0) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        req_r[0] = 1'b1;
        pend = 0;
      end
      if (ack != 3'b000) begin
        if (nacks < 2) begin
          check($sformatf("fair_ack%0d", nacks), ack, exp_seq[nacks]);
          check($sformatf("fair_data%0d", nacks), rgb, exp_dat[nacks]);
        end
        nacks++;
        if (ack[0]) begin
          req_r[0] = 1'b0;
          pend = 1;
        end
        if (ack[2]) begin
          last_ack = cyc;
          req_r = 3'b000;
        end
      end
    end
    check("fair_req2_cycle", last_ack, 9);
    check("fair_req2_txn", nacks, 2);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
